// File: rtl/stoch_scale_dn.sv
// stoch_scale_dn: divides the 1-density of a stochastic bitstream by G (one OUT pulse per G input ones).
// Optional saturating statistics counters enabled by defining SCALE_DN_STAT_EN.
module stoch_scale_dn #(
  parameter int MEML  = 16,
  parameter int STATW = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             IN,
  input  logic [MEML-1:0]  G,
  output logic             OUT,
  output logic [STATW-1:0] IN_CNT,
  output logic [STATW-1:0] OUT_CNT
);
  logic [MEML-1:0] cnt, d_lat, g_eff, d_eff;
  logic [MEML:0]   nxt;
  logic            done, take;
  always_comb begin
    g_eff = (G == '0) ? MEML'(1) : G;
    d_eff = (cnt == '0) ? g_eff : d_lat;
    nxt   = {1'b0, cnt} + 1'b1;
    done  = nxt >= {1'b0, d_eff};
    take  = EN && !CLR && IN;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OUT   <= 1'b0;
      cnt   <= '0;
      d_lat <= MEML'(1);
    end else if (CLR) begin
      OUT <= 1'b0;
      cnt <= '0;
    end else if (take) begin
      if (cnt == '0) d_lat <= g_eff;
      OUT <= done;
      cnt <= done ? '0 : nxt[MEML-1:0];
    end else begin
      OUT <= 1'b0;
    end
  end
`ifdef SCALE_DN_STAT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      IN_CNT  <= '0;
      OUT_CNT <= '0;
    end else if (CLR) begin
      IN_CNT  <= '0;
      OUT_CNT <= '0;
    end else if (take) begin
      IN_CNT  <= (IN_CNT == '1) ? IN_CNT : IN_CNT + 1'b1;
      OUT_CNT <= (!done || OUT_CNT == '1) ? OUT_CNT : OUT_CNT + 1'b1;
    end
  end
`else
  assign IN_CNT  = '0;
  assign OUT_CNT = '0;
`endif
endmodule

// File: tb/tb_stoch_scale_dn.sv
// tb_stoch_scale_dn: directed bench with a group-counting reference model and per-cycle compare.
module tb_stoch_scale_dn;
  localparam int MEML = 4, STATW = 4, SMAX = 15;
  logic CLK = 0, RSTN = 0, EN = 0, CLR = 0, IN = 0;
  logic [MEML-1:0] G = 0;
  logic OUT;
  logic [STATW-1:0] IN_CNT, OUT_CNT;
  int checks = 0, errors = 0;
  int m_ones, m_div, m_in, m_oc;
  bit m_out;
  int ones_seen;

  stoch_scale_dn #(.MEML(MEML), .STATW(STATW)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .CLR(CLR), .IN(IN), .G(G),
    .OUT(OUT), .IN_CNT(IN_CNT), .OUT_CNT(OUT_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference: a group opens at its first accepted one, freezing its divisor; the G-th one closes it.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_ones = 0; m_div = 1; m_out = 0; m_in = 0; m_oc = 0;
    end else if (CLR) begin
      m_ones = 0; m_out = 0; m_in = 0; m_oc = 0;
    end else if (!EN || !IN) begin
      m_out = 0;
    end else begin
      if (m_ones == 0) m_div = (G == 0) ? 1 : int'(G);
      m_ones++;
      if (m_in < SMAX) m_in++;
      m_out = (m_ones == m_div);
      if (m_out) begin
        m_ones = 0;
        if (m_oc < SMAX) m_oc++;
      end
    end
  end

  function automatic int exp_stat(input int v);
`ifdef SCALE_DN_STAT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  always @(negedge CLK) begin
    checks++;
    if (OUT !== m_out || int'(IN_CNT) != exp_stat(m_in) || int'(OUT_CNT) != exp_stat(m_oc)) begin
      errors++;
      $display("FAIL model t=%0t OUT=%b/%b IN_CNT=%0d/%0d OUT_CNT=%0d/%0d", $time,
               OUT, m_out, IN_CNT, exp_stat(m_in), OUT_CNT, exp_stat(m_oc));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit in);
    EN = en; CLR = clr; IN = in;
    @(posedge CLK); #1;
  endtask

  task automatic clear();
    step(1, 1, 1);
    step(0, 0, 0);
  endtask

  initial begin
    bit r;
    #12;
    check("reset_out", int'(OUT), 0);
    check("reset_in_cnt", int'(IN_CNT), 0);
    RSTN = 1;
    @(posedge CLK); #1;

    // G=4 continuous ones: pulses after the 4th, 8th, 12th, 16th
    G = 4; clear(); ones_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 1);
      ones_seen += int'(OUT);
      check($sformatf("g4_c%0d", i), int'(OUT), (i % 4 == 0) ? 1 : 0);
    end
    check("g4_total", ones_seen, 4);

    // G=1 and G=0: OUT is IN delayed one cycle
    for (int g = 1; g >= 0; g--) begin
      G = MEML'(g); clear();
      for (int i = 0; i < 200; i++) begin
        r = 1'($urandom_range(0, 1));
        step(1, 0, r);
        check($sformatf("pass_g%0d", g), int'(OUT), int'(r));
      end
    end

    // G change mid-group is deferred to the next group
    G = 5; clear();
    step(1, 0, 1); step(1, 0, 1);
    G = 2;
    step(1, 0, 1); check("gchg_3", int'(OUT), 0);
    step(1, 0, 1); check("gchg_4", int'(OUT), 0);
    step(1, 0, 1); check("gchg_5", int'(OUT), 1);
    step(1, 0, 1); check("gchg_n1", int'(OUT), 0);
    step(1, 0, 1); check("gchg_n2", int'(OUT), 1);

    // EN toggling: disabled cycles neither count nor pulse
    G = 3; clear();
    step(1, 0, 1); check("en_a", int'(OUT), 0);
    step(0, 0, 1); check("en_b", int'(OUT), 0);
    step(1, 0, 1); check("en_c", int'(OUT), 0);
    step(0, 0, 1); check("en_d", int'(OUT), 0);
    step(1, 0, 1); check("en_e", int'(OUT), 1);
    step(0, 0, 1); check("en_f", int'(OUT), 0);

    // CLR mid-group drops partial count and the IN on that cycle
    clear();
    step(1, 0, 1); step(1, 0, 1);
    step(1, 1, 1); check("clr_out", int'(OUT), 0);
    step(1, 0, 1); check("clr_1", int'(OUT), 0);
    step(1, 0, 1); check("clr_2", int'(OUT), 0);
    step(1, 0, 1); check("clr_3", int'(OUT), 1);

    // Async reset mid-group behaves the same
    step(1, 0, 1); step(1, 0, 1);
    EN = 0; IN = 0; RSTN = 0; #2;
    check("rst_out", int'(OUT), 0);
    RSTN = 1;
    @(posedge CLK); #1;
    step(1, 0, 1); check("rst_1", int'(OUT), 0);
    step(1, 0, 1); check("rst_2", int'(OUT), 0);
    step(1, 0, 1); check("rst_3", int'(OUT), 1);

    // Largest divisor
    G = 15; clear();
    for (int i = 1; i <= 15; i++) begin
      step(1, 0, 1);
      check($sformatf("gmax_%0d", i), int'(OUT), (i == 15) ? 1 : 0);
    end

    // Stats saturate, CLR zeroes them
    G = 1; clear();
    for (int i = 0; i < 20; i++) step(1, 0, 1);
    check("stat_in_sat", int'(IN_CNT), exp_stat(15));
    check("stat_out_sat", int'(OUT_CNT), exp_stat(15));
    step(1, 1, 0);
    check("stat_in_clr", int'(IN_CNT), 0);
    check("stat_out_clr", int'(OUT_CNT), 0);

    @(negedge CLK); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
